posit_decode_arbiter: RTL and testbench
=======================================

# posit_decode_arbiter

Shares one posit-to-PIF decoder (`posit_to_pif`) between `NREQ` operand requesters, such as the PPU operand A/B fetch paths and the accumulator reload path. Each accepted posit is decoded and held in a single registered output slot, tagged with its requester id. Arbitration is round-robin, the handshake is valid/ready on both sides, and throughput is one decode per cycle when the consumer does not stall.

## Interface
Parameters:
- `N`, 16, posit width in bits
- `ES`, 1, exponent field size
- `NREQ`, 2, number of requesters (at least 2)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous and active-high
- `req_valid`  in  NREQ  request valid, one bit per requester
- `req_bits`  in  NREQ*N  posits; requester i occupies bits [i*N +: N]
- `req_ready`  out  NREQ  one-hot grant; the request is accepted when valid and ready are both high
- `out_valid`  out  1  decoded result present
- `out_ready`  in  1  consumer accepts the result
- `out_pif`  out  PIF_SIZE  {sign, te, mant} of the accepted posit
- `out_id`  out  ID_W  index of the requester that produced `out_pif`

## Operation
- `can_accept = !out_valid || out_ready`.
- Grant: when `can_accept` is high and any `req_valid` is set, assert exactly one `req_ready` bit, for the first valid requester at or after `ptr+1` (mod NREQ). Otherwise `req_ready` is all zero.
- `req_ready` is combinational from `req_valid`, `ptr`, `out_valid`, `out_ready` and `rst`. It is forced to 0 while `rst` is high.
- `req_ready` never depends on `req_bits`.
- On acceptance of requester g:
  - `req_bits[g]` is routed through the mux to the single decoder instance.
  - At the clock edge: `out_pif` takes the decoder output, `out_id` takes g, `out_valid` goes to 1, and `ptr` takes g.
- Drain without a new grant: when `out_valid && out_ready` and no grant occurs, `out_valid` goes to 0.
  - `out_pif` and `out_id` keep their last values; they are don't-care while `out_valid` is 0.
- Stall: when `out_valid && !out_ready`, `out_pif`, `out_id` and `out_valid` hold and no grant is issued.
- `ptr` updates only on a grant. Idle cycles do not rotate priority.
- Zero (0x0000) and NaR (0x8000) are not special-cased. They pass through the decoder, and `out_pif` is exactly the decoder output.
- Protocol rules on requesters and consumer:
  - A requester holds `req_valid` and `req_bits` stable until it is granted.
  - The consumer sees `out_valid`, `out_pif` and `out_id` stable until the transfer completes.
  - `req_valid` may be withdrawn only after a grant; the bench treats earlier withdrawal as a protocol error.

## Timing
- Latency: a posit accepted in cycle t appears on `out_pif`/`out_valid` in cycle t+1.
- Throughput: one result per cycle when `out_ready` is held high. A simultaneous drain and grant in the same cycle is required (no bubble).
- Reset values, applied at the first edge with `rst` high:
  - `out_valid` = 0, `out_pif` = 0, `out_id` = 0.
  - `ptr` = NREQ-1, so requester 0 has highest priority first.
- Reset mid-operation: a pending output is discarded and `out_valid` is 0 after the edge. Requests held across reset are re-arbitrated from `ptr` = NREQ-1.
- The decode path from the mux through the decoder to the `out_pif` register is a single-cycle combinational path.

## Structure
- Shared package `ppu_pkg` holds the width definitions:
  - `TE_SIZE = ES + $clog2(N) + 1`
  - `MANT_SIZE = N - 2`
  - `PIF_SIZE = 1 + TE_SIZE + MANT_SIZE`
  - `ID_W = max(1, $clog2(NREQ))`
- The decoder and `posit_to_pif` use these same package definitions.
- Sub-module `rr_arbiter` (parameter `NREQ`):
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and binary `gnt_idx`.
  - Purely combinational.
  - `ptr` stays in the parent.
- Exactly one `posit_to_pif` instance.

## Test plan
All scenarios use N=16, ES=1, NREQ=2. The golden model is a standalone `posit_to_pif` fed the same posit.
- Reset: `rst` high for 2 cycles with all `req_valid` = 1 → `req_ready` = 00 and `out_valid` = 0. In the first cycle after release the grant is 01 (requester 0).
- Fairness: both requesters valid continuously, `out_ready` = 1 → grants 0,1,0,1…; `out_id` is 0,1,0,1… one cycle later with no bubbles. Over 100 cycles, exactly 50 grants each.
- Backpressure: `out_valid` = 1, `out_ready` = 0 for 5 cycles → `req_ready` = 00 and `out_pif`/`out_id` stable. Raising `out_ready` grants a new request in that same cycle.
- Single requester: only requester 1 valid with 0x4000 (+1.0) → `req_ready` = 10 immediately. The next cycle shows `out_id` = 1, sign = 0, te = 0, mant equal to the model. Then 0xC000 (−1.0) → sign = 1, te = 0.
- Specials: 0x0000 and 0x8000 → `out_pif` bit-exact to the model.
- Mid-reset: `rst` pulsed while `out_valid` = 1 and `out_ready` = 0 → `out_valid` = 0 after the edge. After release, requester 0 wins over a simultaneous request from requester 1.

Source files
------------

// File: rtl/ppu_pkg.sv
// Width helpers for the posit intermediate format (PIF) shared by the decoder
// and everything that carries decoded operands.
package ppu_pkg;

  function automatic int te_size(input int n, input int es);
    return es + $clog2(n) + 1;
  endfunction

  function automatic int mant_size(input int n);
    return n - 2;
  endfunction

  function automatic int pif_size(input int n, input int es);
    return 1 + te_size(n, es) + mant_size(n);
  endfunction

  function automatic int id_w(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/posit_to_pif.sv
// Combinational posit decoder: produces {sign, total exponent, mantissa with
// hidden bit} from an N-bit posit. Zero and NaR are not special-cased.
module posit_to_pif
  import ppu_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 1
) (
  input  logic [N-1:0]                posit,
  output logic [pif_size(N, ES)-1:0]  pif
);

  localparam int TE_W   = te_size(N, ES);
  localparam int MANT_W = mant_size(N);

  logic              sign;
  logic [N-1:0]      mag;
  logic [N-2:0]      body;
  logic [N-2:0]      shifted;
  logic [N-2:0]      frac_al;
  logic              reg_bit;
  logic              done;
  int                run;
  int                k;
  int                e;
  logic [TE_W-1:0]   te;
  logic [MANT_W-1:0] mant;

  always_comb begin
    sign    = posit[N-1];
    mag     = sign ? (~posit + {{(N-1){1'b0}}, 1'b1}) : posit;
    body    = mag[N-2:0];
    reg_bit = body[N-2];
    run     = 0;
    done    = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done) begin
        if (body[i] == reg_bit) run = run + 1;
        else done = 1'b1;
      end
    end
    // Drop the regime run and its terminator; exponent then fraction remain.
    shifted = body << (run + 1);
    e       = int'(shifted >> (N - 1 - ES));
    frac_al = shifted << ES;
    k       = reg_bit ? (run - 1) : -run;
    te      = TE_W'(k * (2 ** ES) + e);
    mant    = {1'b1, frac_al[N-2 -: MANT_W-1]};
    pif     = {sign, te, mant};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr+1.
module rr_arbiter
  import ppu_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]       req,
  input  logic [id_w(NREQ)-1:0] ptr,
  input  logic                  en,
  output logic [NREQ-1:0]       gnt,
  output logic [id_w(NREQ)-1:0] gnt_idx
);

  localparam int ID_W = id_w(NREQ);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(ptr) + off) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/posit_decode_arbiter.sv
// Shares one posit_to_pif decoder among NREQ requesters with round-robin
// grants and a single registered, id-tagged output slot.
module posit_decode_arbiter
  import ppu_pkg::*;
#(
  parameter int N    = 16,
  parameter int ES   = 1,
  parameter int NREQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*N-1:0]          req_bits,
  output logic [NREQ-1:0]            req_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [pif_size(N, ES)-1:0] out_pif,
  output logic [id_w(NREQ)-1:0]      out_id
);

  localparam int PIF_W = pif_size(N, ES);
  localparam int ID_W  = id_w(NREQ);

  logic [N-1:0]      req_arr [NREQ];
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              can_accept;
  logic              arb_en;
  logic [N-1:0]      dec_in;
  logic [PIF_W-1:0]  dec_pif;

  logic              out_valid_q, out_valid_d;
  logic [PIF_W-1:0]  out_pif_q, out_pif_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_arr[gi] = req_bits[gi*N +: N];
    end
  endgenerate

  assign can_accept = !out_valid_q || out_ready;
  assign arb_en     = can_accept && !rst;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign dec_in = req_arr[gnt_idx];

  posit_to_pif #(.N(N), .ES(ES)) u_dec (
    .posit (dec_in),
    .pif   (dec_pif)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_pif_d   = out_pif_q;
    out_id_d    = out_id_q;
    ptr_d       = ptr_q;
    if (|gnt) begin
      // A grant also covers the drain of the current slot, so no bubble.
      out_valid_d = 1'b1;
      out_pif_d   = dec_pif;
      out_id_d    = gnt_idx;
      ptr_d       = gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pif_q   <= '0;
      out_id_q    <= '0;
      ptr_q       <= ID_W'(NREQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_pif_q   <= out_pif_d;
      out_id_q    <= out_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign req_ready = gnt;
  assign out_valid = out_valid_q;
  assign out_pif   = out_pif_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Directed bench for posit_decode_arbiter (N=16, ES=1, NREQ=2).
module tb_posit_decode_arbiter;

  localparam int N     = 16;
  localparam int ES    = 1;
  localparam int NREQ  = 2;
  localparam int PIF_W = 21;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_bits;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [PIF_W-1:0]  out_pif;
  logic [0:0]        out_id;

  logic [N-1:0]      model_in;
  logic [PIF_W-1:0]  model_pif;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  posit_decode_arbiter #(.N(N), .ES(ES), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bits  (req_bits),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pif   (out_pif),
    .out_id    (out_id)
  );

  posit_to_pif #(.N(N), .ES(ES)) u_model (
    .posit (model_in),
    .pif   (model_pif)
  );

  typedef struct {
    logic [N-1:0]     posit;
    int               id;
    logic [PIF_W-1:0] exp_pif;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %s act=%0h exp=%0h", name, act, exp);
    end else begin
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  initial begin
    vec_t vecs [7];
    int   cnt0, cnt1, seq_err, id_err, exp_g, prev_g, g;

    vecs[0] = '{16'h4000, 1, 21'h002000};
    vecs[1] = '{16'hC000, 1, 21'h102000};
    vecs[2] = '{16'h0000, 0, 21'h08A000};
    vecs[3] = '{16'h8000, 1, 21'h18A000};
    vecs[4] = '{16'h5000, 0, 21'h006000};
    vecs[5] = '{16'h6000, 1, 21'h00A000};
    vecs[6] = '{16'h4800, 0, 21'h003000};

    // Reset held two cycles with both requesters asserting.
    rst       = 1'b1;
    req_valid = 2'b11;
    req_bits  = {16'h6000, 16'h4000};
    out_ready = 1'b1;
    model_in  = 16'h0000;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("reset_ready_c%0d", c), 32'(req_ready), 32'h0);
      check($sformatf("reset_valid_c%0d", c), 32'(out_valid), 32'h0);
    end
    check("reset_pif", 32'(out_pif), 32'h0);
    check("reset_id", 32'(out_id), 32'h0);
    rst = 1'b0;
    #1;
    check("post_reset_grant", 32'(req_ready), 32'h1);

    // Fairness: both valid, consumer always ready.
    cnt0 = 0; cnt1 = 0; seq_err = 0; id_err = 0; prev_g = 0;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
        if (!out_valid || out_id != 1'(prev_g)) id_err++;
      end
      exp_g = c % 2;
      g = req_ready[1] ? 1 : 0;
      if (req_ready != (exp_g == 1 ? 2'b10 : 2'b01)) seq_err++;
      if (req_ready == 2'b01) cnt0++;
      if (req_ready == 2'b10) cnt1++;
      prev_g = g;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    check("fair_grant_seq_errs", 32'(seq_err), 32'h0);
    check("fair_out_id_errs", 32'(id_err), 32'h0);
    check("fair_cnt0", 32'(cnt0), 32'd50);
    check("fair_cnt1", 32'(cnt1), 32'd50);
    check("fair_last_id", 32'(out_id), 32'h1);

    // Backpressure: slot holds requester 1's 0x6000 result.
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'h0);
      check($sformatf("bp_pif_c%0d", c), 32'(out_pif), 32'h00A000);
      check($sformatf("bp_id_c%0d", c), 32'(out_id), 32'h1);
      check($sformatf("bp_valid_c%0d", c), 32'(out_valid), 32'h1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("bp_release_id", 32'(out_id), 32'h0);
    check("bp_release_pif", 32'(out_pif), 32'h002000);

    // Mid-operation reset while stalled; ptr=0 would otherwise favour req 1.
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_ready", 32'(req_ready), 32'h0);
    rst = 1'b0;
    #1;
    check("midrst_grant_req0", 32'(req_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("midrst_out_id", 32'(out_id), 32'h0);
    req_valid = 2'b00;
    out_ready = 1'b1;

    // Single-requester decode vectors.
    for (int v = 0; v < 7; v++) begin
      req_valid = 2'b00;
      req_bits  = '0;
      req_valid[vecs[v].id] = 1'b1;
      req_bits[vecs[v].id*N +: N] = vecs[v].posit;
      model_in = vecs[v].posit;
      #1;
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_id", v), 32'(out_id), 32'(vecs[v].id));
      check($sformatf("vec%0d_pif", v), 32'(out_pif), 32'(vecs[v].exp_pif));
      check($sformatf("vec%0d_model", v), 32'(out_pif), 32'(model_pif));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check("drain_valid", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
